packet_dispatcher: RTL

//  Sequencer between the PC_RX FIFO, PC_TX serialiser and SLM config register bank. On each decoded

---
 rtl/packet_dispatcher.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/packet_dispatcher.sv
// packet_dispatcher: sequences RX FIFO packets into loopback, config write, config readback or discard.
// Build option DISPATCH_ECHO_HEADER_EN: LOOP and RD send the header word to TX ahead of the payload.
module packet_dispatcher #(
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 16,
  parameter int CFG_ADDR_W  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [1:0]            i_packet_command,
  input  logic                  i_packet_fully_decoded,
  input  logic                  i_rx_fifo_is_empty_sig,
  input  logic [DATA_W-1:0]     i_rx_fifo_output_word,
  output logic                  o_rx_fifo_next_word_cmd,
  input  logic                  i_serial_is_busy_sig,
  output logic [DATA_W-1:0]     o_data_manager_output_data_word,
  output logic                  o_data_manager_output_next_cmd,
  output logic                  o_cfg_wr_en,
  output logic [CFG_ADDR_W-1:0] o_cfg_addr,
  output logic [DATA_W-1:0]     o_cfg_wr_data,
  input  logic [DATA_W-1:0]     i_cfg_rd_data,
  output logic                  o_busy,
  output logic                  o_error
);

`ifdef DISPATCH_ECHO_HEADER_EN
  localparam bit ECHO_HDR = 1'b1;
`else
  localparam bit ECHO_HDR = 1'b0;
`endif
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_LOOP, S_WR, S_RD, S_DROP} state_t;
  typedef enum logic [1:0] {CMD_LOOP, CMD_WR, CMD_RD, CMD_DROP} cmd_t;

  state_t                state;
  cmd_t                  cmd;
  logic [LEN_W-1:0]      remaining;
  logic [CFG_ADDR_W-1:0] wr_addr;
  logic                  gap;
  logic [TO_W-1:0]       empty_cnt;
  logic                  hdr_pending;
  logic [DATA_W-1:0]     hdr_word;

  logic [LEN_W-1:0]      hdr_len;
  logic [CFG_ADDR_W-1:0] hdr_base;
  logic                  pop_ok;
  logic                  tx_ok;
  logic                  last_word;
  logic                  watched;
  logic                  timeout_hit;

  assign hdr_len     = i_rx_fifo_output_word[DATA_W-1 -: LEN_W];
  assign hdr_base    = i_rx_fifo_output_word[CFG_ADDR_W-1:0];
  // The FIFO head only advances on the edge after a strobe, so every pop/start is followed by a gap.
  assign pop_ok      = !i_rx_fifo_is_empty_sig && !gap;
  assign tx_ok       = !i_serial_is_busy_sig && !gap;
  assign last_word   = (remaining == LEN_W'(1));
  assign watched     = (state == S_HDR) || (state == S_LOOP) || (state == S_WR) || (state == S_DROP);
  assign timeout_hit = watched && i_rx_fifo_is_empty_sig && (empty_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign o_busy      = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state                           <= S_IDLE;
      cmd                             <= CMD_LOOP;
      remaining                       <= '0;
      wr_addr                         <= '0;
      gap                             <= 1'b0;
      empty_cnt                       <= '0;
      hdr_pending                     <= 1'b0;
      hdr_word                        <= '0;
      o_rx_fifo_next_word_cmd         <= 1'b0;
      o_data_manager_output_data_word <= '0;
      o_data_manager_output_next_cmd  <= 1'b0;
      o_cfg_wr_en                     <= 1'b0;
      o_cfg_addr                      <= '0;
      o_cfg_wr_data                   <= '0;
      o_error                         <= 1'b0;
    end else begin
      // NOTE: strobes default low here so each is a single-cycle pulse unless re-asserted below.
      o_rx_fifo_next_word_cmd        <= 1'b0;
      o_data_manager_output_next_cmd <= 1'b0;
      o_cfg_wr_en                    <= 1'b0;
      o_error                        <= 1'b0;
      gap                            <= 1'b0;

      if (!watched || !i_rx_fifo_is_empty_sig) empty_cnt <= '0;
      else                                     empty_cnt <= empty_cnt + 1'b1;

      if (i_packet_fully_decoded && state != S_IDLE) o_error <= 1'b1;

      if (timeout_hit) begin
        o_error <= 1'b1;
        state   <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (i_packet_fully_decoded) begin
            cmd   <= cmd_t'(i_packet_command);
            state <= S_HDR;
          end
          S_HDR: if (pop_ok) begin
            o_rx_fifo_next_word_cmd <= 1'b1;
            gap                     <= 1'b1;
            remaining               <= hdr_len;
            wr_addr                 <= hdr_base;
            o_cfg_addr              <= hdr_base;
            hdr_word                <= i_rx_fifo_output_word;
            hdr_pending             <= ECHO_HDR && (hdr_len != '0) && (cmd == CMD_LOOP || cmd == CMD_RD);
            if (hdr_len == '0) state <= S_IDLE;
            else begin
              case (cmd)
                CMD_LOOP: state <= S_LOOP;
                CMD_WR:   state <= S_WR;
                CMD_RD:   state <= S_RD;
                CMD_DROP: state <= S_DROP;
              endcase
            end
          end
          S_LOOP: begin
            if (hdr_pending) begin
              if (tx_ok) begin
                o_data_manager_output_next_cmd  <= 1'b1;
                o_data_manager_output_data_word <= hdr_word;
                gap                             <= 1'b1;
                hdr_pending                     <= 1'b0;
              end
            end else if (pop_ok && !i_serial_is_busy_sig) begin
              o_rx_fifo_next_word_cmd         <= 1'b1;
              o_data_manager_output_next_cmd  <= 1'b1;
              o_data_manager_output_data_word <= i_rx_fifo_output_word;
              gap                             <= 1'b1;
              remaining                       <= remaining - 1'b1;
              if (last_word) state <= S_IDLE;
            end
          end
          S_WR: if (pop_ok) begin
            o_rx_fifo_next_word_cmd <= 1'b1;
            o_cfg_wr_en             <= 1'b1;
            o_cfg_addr              <= wr_addr;
            o_cfg_wr_data           <= i_rx_fifo_output_word;
            wr_addr                 <= wr_addr + 1'b1;
            gap                     <= 1'b1;
            remaining               <= remaining - 1'b1;
            if (last_word) state <= S_IDLE;
          end
          S_RD: begin
            // o_cfg_addr was set at least one cycle earlier, so i_cfg_rd_data has settled.
            if (hdr_pending) begin
              if (tx_ok) begin
                o_data_manager_output_next_cmd  <= 1'b1;
                o_data_manager_output_data_word <= hdr_word;
                gap                             <= 1'b1;
                hdr_pending                     <= 1'b0;
              end
            end else if (tx_ok) begin
              o_data_manager_output_next_cmd  <= 1'b1;
              o_data_manager_output_data_word <= i_cfg_rd_data;
              o_cfg_addr                      <= o_cfg_addr + 1'b1;
              gap                             <= 1'b1;
              remaining                       <= remaining - 1'b1;
              if (last_word) state <= S_IDLE;
            end
          end
          S_DROP: if (pop_ok) begin
            o_rx_fifo_next_word_cmd <= 1'b1;
            gap                     <= 1'b1;
            remaining               <= remaining - 1'b1;
            if (last_word) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
